sfp_port_status: RTL
====================

# sfp_port_status

Multi-port SFP status and LED controller: the parametrised successor to the single-port LED/blink logic in our top level. For each of NUM_PORTS cages it synchronises RX_LOS and TX_FAULT, debounces the link, and runs a per-port state machine that drives TX_DISABLE. It also drives two LEDs per port (link/fault and stretched activity) from one shared blink counter. It sits in the top level between the SFP cage pins and the MAC statistics strobes, all on the 156.25 MHz core clock.

## Interface
- NUM_PORTS, 4: number of SFP ports (≥1).
- BLINK_BITS, 25: width of the free-running blink counter; blink period 2^BLINK_BITS cycles.
- DEBOUNCE_CYCLES, 65536: consecutive clean cycles required for link-up and fault recovery (≥1).
- STRETCH_CYCLES, 2^20: activity LED on-time per frame event (≥1).

Ports:
- clk_i, in, 1: core clock; all logic runs on it.
- resetn_i, in, 1: reset, asynchronous and active-low.
- port_enable_i, in, NUM_PORTS: software enable per port.
- rx_los_i, in, NUM_PORTS: SFP loss of signal; asynchronous.
- tx_fault_i, in, NUM_PORTS: SFP transmitter fault; asynchronous.
- frame_sent_i, in, NUM_PORTS: one-cycle MAC tx statistics strobe; synchronous.
- frame_received_i, in, NUM_PORTS: one-cycle MAC rx statistics strobe; synchronous.
- tx_disable_o, out, NUM_PORTS: laser disable per port.
- link_up_o, out, NUM_PORTS: high while the port is in UP.
- led_o, out, 2*NUM_PORTS: led_o[2p] is link/fault and led_o[2p+1] is activity for port p.
- blink_o, out, 1: MSB of the blink counter.

## Operation
- rx_los_i and tx_fault_i each pass through a 2-flop synchroniser, giving los_s and flt_s.
- Each port has a state machine (DISABLED, DOWN, UP, FAULT) and one debounce counter. The counter clears on every state change.
- Transition priority, highest first: !port_enable_i, then flt_s, then los_s.
  - Any state with !port_enable_i goes to DISABLED.
  - DISABLED with enable goes to DOWN.
  - DOWN or UP with flt_s goes to FAULT.
  - UP with los_s goes to DOWN immediately.
  - DOWN: the counter increments while !los_s and clears when los_s. The state goes to UP on the cycle the counter would reach DEBOUNCE_CYCLES.
  - FAULT: the counter increments while !flt_s and clears when flt_s. The state goes to DOWN on the cycle it would reach DEBOUNCE_CYCLES.
- tx_disable_o is 1 in DISABLED and FAULT, and 0 in DOWN and UP.
- Activity stretch counter per port:
  - Loads STRETCH_CYCLES when the port is UP and (frame_sent_i | frame_received_i); a retrigger reloads it.
  - Otherwise it decrements to 0.
  - It is forced to 0 when the port is not UP.
- LEDs per port:
  - led_o[2p] is 1 in UP, blink_o in FAULT, and 0 in DOWN and DISABLED.
  - led_o[2p+1] is 1 when the stretch counter is non-zero.
- Width rules:
  - Debounce counter width is $clog2(DEBOUNCE_CYCLES+1) and it never wraps.
  - Stretch counter width is $clog2(STRETCH_CYCLES+1).
  - The blink counter wraps freely.
- Reset values: state DISABLED, all counters 0, tx_disable_o all 1, link_up_o 0, led_o 0, blink_o 0.
- Reset asserted mid-operation returns everything to these values immediately (asynchronous reset).

## Timing
- All outputs are decoded from registered state and counters only; there is no input-to-output combinational path.
- Edge 1 is the first edge that samples a change on rx_los_i or tx_fault_i; the synchronised value is visible after edge 2.
- Link-down latency: link_up_o falls at edge 3.
- Link-up latency: link_up_o rises at edge 2+DEBOUNCE_CYCLES, provided rx_los_i stays low throughout.
- Fault entry: tx_disable_o rises at edge 3. Recovery to DOWN happens at edge 2+DEBOUNCE_CYCLES after tx_fault_i is first sampled low.
- port_enable_i and the frame strobes are synchronous; they take effect on the next edge.
- Activity: led_o[2p+1] is high for exactly STRETCH_CYCLES cycles after the edge sampling the last strobe.
- blink_o toggles every 2^(BLINK_BITS-1) cycles.

## Structure
- Package sfp_status_pkg:
  - 2-bit port state enum: DISABLED=0, DOWN=1, UP=2, FAULT=3.
  - LED index constants LED_LINK=0 and LED_ACT=1.
- Sub-module sfp_port_fsm contains the synchronisers, state machine, debounce counter and stretch counter for one port. The top instantiates it NUM_PORTS times in a generate loop and owns the shared blink counter.

## Test plan
All scenarios use NUM_PORTS=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8, BLINK_BITS=4.
- Reset: resetn_i low. Require tx_disable_o=2'b11, led_o=0, link_up_o=0, blink_o=0. Then release and set port_enable_i=2'b11 with rx_los_i=2'b11: tx_disable_o=0 after 1 cycle and link_up_o stays 0.
- Link-up debounce: drop rx_los_i[0]. Require link_up_o[0] high exactly at edge 6. A 3-cycle-long drop followed by LOS gives no link-up.
- Link-down: with port 0 UP, raise rx_los_i[0]. Require link_up_o[0]=0 and led_o[0]=0 at edge 3.
- Fault overrides link:
  - Raise tx_fault_i[1] while port 1 is UP with LOS low. Require tx_disable_o[1]=1 at edge 3 and led_o[2] to follow blink_o.
  - After the fault clears, the port returns to DOWN 6 edges later, then goes UP 4 cycles after that.
- Activity stretch and port-disable reset:
  - A frame_received_i[0] pulse holds led_o[1] high for 8 cycles.
  - A second pulse at cycle 5 extends the on-time to cycle 13.
  - Pulses while the port is DOWN leave led_o[1]=0.
  - Deasserting port_enable_i mid-stretch clears led_o[1] and sets tx_disable_o[0]=1 next cycle.
- Asynchronous reset mid-debounce: assert resetn_i at count 2. All outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/sfp_status_pkg.sv
// Shared types and constants for the multi-port SFP status / LED controller.
//   port_state_e : per-port state machine encoding
//   LED_LINK     : offset of the link/fault LED within a port's LED pair
//   LED_ACT      : offset of the activity LED within a port's LED pair
package sfp_status_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        DOWN     = 2'd1,
        UP       = 2'd2,
        FAULT    = 2'd3
    } port_state_e;

    localparam int unsigned LED_LINK = 0;
    localparam int unsigned LED_ACT  = 1;

endpackage

// File: rtl/sfp_port_fsm.sv
// Status logic for one SFP cage: RX_LOS / TX_FAULT synchronisers, link state
// machine with debounce counter, and activity-LED stretch counter.
// Ports:
//   clk_i, resetn_i      core clock, asynchronous active-low reset
//   enable_i             software enable for this port
//   rx_los_i, tx_fault_i asynchronous cage status pins
//   frame_sent_i,
//   frame_received_i     one-cycle MAC statistics strobes
//   blink_i              shared blink phase, shown on the link LED in FAULT
//   tx_disable_o         laser disable
//   link_up_o            high while in UP
//   led_link_o           link/fault LED
//   led_act_o            stretched activity LED
module sfp_port_fsm
    import sfp_status_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned STRETCH_CYCLES  = 1 << 20
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic enable_i,
    input  logic rx_los_i,
    input  logic tx_fault_i,
    input  logic frame_sent_i,
    input  logic frame_received_i,
    input  logic blink_i,
    output logic tx_disable_o,
    output logic link_up_o,
    output logic led_link_o,
    output logic led_act_o
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned StW = $clog2(STRETCH_CYCLES + 1);

    // Count value whose increment would reach DEBOUNCE_CYCLES.
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [StW-1:0] StLoad = StW'(STRETCH_CYCLES);

    logic [1:0]     los_sync_q;
    logic [1:0]     flt_sync_q;
    logic           los_s;
    logic           flt_s;
    port_state_e    state_q, state_d;
    logic [DbW-1:0] db_q, db_d;
    logic [StW-1:0] st_q, st_d;

    assign los_s = los_sync_q[1];
    assign flt_s = flt_sync_q[1];

    // LOS synchroniser resets to "signal lost" so no debounce credit is earned
    // before the real pin value arrives; fault resets clear so an enabled
    // port is not pushed into FAULT by the reset value itself.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            los_sync_q <= 2'b11;
            flt_sync_q <= 2'b00;
        end else begin
            los_sync_q <= {los_sync_q[0], rx_los_i};
            flt_sync_q <= {flt_sync_q[0], tx_fault_i};
        end
    end

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        unique case (state_q)
            DISABLED: begin
                state_d = DOWN;
            end
            DOWN: begin
                if (flt_s) begin
                    state_d = FAULT;
                end else if (los_s) begin
                    db_d = '0;
                end else if (db_q == DbLast) begin
                    state_d = UP;
                end else begin
                    db_d = db_q + DbW'(1);
                end
            end
            UP: begin
                if (flt_s) begin
                    state_d = FAULT;
                end else if (los_s) begin
                    state_d = DOWN;
                end
            end
            FAULT: begin
                if (flt_s) begin
                    db_d = '0;
                end else if (db_q == DbLast) begin
                    state_d = DOWN;
                end else begin
                    db_d = db_q + DbW'(1);
                end
            end
            default: begin
                state_d = DISABLED;
            end
        endcase
        // Disable outranks every other transition.
        if (!enable_i) begin
            state_d = DISABLED;
        end
        if (state_d != state_q) begin
            db_d = '0;
        end
    end

    // Forcing on the next state lets a disable or link drop blank the LED on
    // the same edge the state leaves UP.
    always_comb begin
        st_d = st_q;
        if (state_d != UP) begin
            st_d = '0;
        end else if ((state_q == UP) && (frame_sent_i || frame_received_i)) begin
            st_d = StLoad;
        end else if (st_q != '0) begin
            st_d = st_q - StW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= DISABLED;
            db_q    <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            db_q    <= db_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        tx_disable_o = (state_q == DISABLED) || (state_q == FAULT);
        link_up_o    = (state_q == UP);
        led_link_o   = (state_q == UP) || ((state_q == FAULT) && blink_i);
        led_act_o    = (st_q != '0);
    end

endmodule

// File: rtl/sfp_port_status.sv
// Multi-port SFP status and LED controller. One sfp_port_fsm per cage plus a
// shared free-running blink counter.
// Ports:
//   clk_i, resetn_i   core clock, asynchronous active-low reset
//   port_enable_i     software enable per port
//   rx_los_i          SFP loss of signal per port (asynchronous)
//   tx_fault_i        SFP transmitter fault per port (asynchronous)
//   frame_sent_i      MAC tx statistics strobe per port
//   frame_received_i  MAC rx statistics strobe per port
//   tx_disable_o      laser disable per port
//   link_up_o         high while the port is UP
//   led_o             {activity, link/fault} pair per port
//   blink_o           MSB of the blink counter
module sfp_port_status
    import sfp_status_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned BLINK_BITS      = 25,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned STRETCH_CYCLES  = 1 << 20
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    input  logic [NUM_PORTS-1:0]   port_enable_i,
    input  logic [NUM_PORTS-1:0]   rx_los_i,
    input  logic [NUM_PORTS-1:0]   tx_fault_i,
    input  logic [NUM_PORTS-1:0]   frame_sent_i,
    input  logic [NUM_PORTS-1:0]   frame_received_i,
    output logic [NUM_PORTS-1:0]   tx_disable_o,
    output logic [NUM_PORTS-1:0]   link_up_o,
    output logic [2*NUM_PORTS-1:0] led_o,
    output logic                   blink_o
);

    logic [BLINK_BITS-1:0] blink_q, blink_d;

    assign blink_d = blink_q + BLINK_BITS'(1);
    assign blink_o = blink_q[BLINK_BITS-1];

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        sfp_port_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STRETCH_CYCLES  (STRETCH_CYCLES)
        ) u_port (
            .clk_i            (clk_i),
            .resetn_i         (resetn_i),
            .enable_i         (port_enable_i[p]),
            .rx_los_i         (rx_los_i[p]),
            .tx_fault_i       (tx_fault_i[p]),
            .frame_sent_i     (frame_sent_i[p]),
            .frame_received_i (frame_received_i[p]),
            .blink_i          (blink_o),
            .tx_disable_o     (tx_disable_o[p]),
            .link_up_o        (link_up_o[p]),
            .led_link_o       (led_o[2*p+LED_LINK]),
            .led_act_o        (led_o[2*p+LED_ACT])
        );
    end

endmodule
